// File: rtl/lattice_sched_if.sv
// Host command/data port and cell-array scan port of the lattice sequencer.
// The slave modport is the sequencer's view; master is the host plus cell array.
interface lattice_sched_if #(
  parameter int NCELLS = 16,
  parameter int GEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [GEN_W-1:0]  cmd_arg;
  logic [3:0]        din;
  logic              din_valid;
  logic              din_ready;
  logic [3:0]        dout;
  logic              dout_valid;
  logic              cell_en;
  logic              scan_en;
  logic [3:0]        scan_in;
  logic [3:0]        scan_out;
  logic [NCELLS-1:0] rnd;
  logic [GEN_W-1:0]  gen;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, din, din_valid, scan_out,
    output cmd_ready, din_ready, dout, dout_valid, cell_en, scan_en,
           scan_in, rnd, gen, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg, din, din_valid, scan_out,
    input  cmd_ready, din_ready, dout, dout_valid, cell_en, scan_en,
           scan_in, rnd, gen, busy
  );
endinterface

// File: rtl/lattice_sched.sv
// Lattice-gas row sequencer: scan-chain load/dump, generation stepping,
// per-cell random bits from a 16-bit Galois LFSR and a generation counter.
module lattice_sched #(
  parameter int          NCELLS = 16,
  parameter int          GEN_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  lattice_sched_if.slave bus
);

  localparam logic [2:0] OP_STEP = 3'b001;
  localparam logic [2:0] OP_RUN  = 3'b010;
  localparam logic [2:0] OP_STOP = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_DUMP = 3'b101;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [4:0]  LAST_CELL = 5'(NCELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_LOAD,
    S_DUMP
  } state_t;

  state_t           r_state;
  logic [GEN_W-1:0] r_gen;
  logic [15:0]      r_lfsr;
  logic [GEN_W-1:0] r_remaining;
  logic [4:0]       r_count;

  logic             w_cell_en;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_stop;
  logic [15:0]      w_lfsr_next;

  assign w_cell_en   = (r_state == S_STEP) || (r_state == S_RUN);
  assign w_cmd_ready = (r_state == S_IDLE) || w_cell_en;
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_stop      = w_accept && (bus.cmd_op == OP_STOP);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gen       <= '0;
      r_lfsr      <= SEED;
      r_remaining <= '0;
      r_count     <= '0;
    end else begin
      // Cells see the pre-advance rnd during a generation; both move at its end.
      if (w_cell_en) begin
        r_gen  <= r_gen + 1'b1;
        r_lfsr <= w_lfsr_next;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.cmd_op)
              OP_STEP: begin
                if (bus.cmd_arg != '0) begin
                  r_state     <= S_STEP;
                  r_remaining <= bus.cmd_arg;
                end
              end
              OP_RUN:  r_state <= S_RUN;
              OP_LOAD: begin
                r_state <= S_LOAD;
                r_count <= '0;
              end
              OP_DUMP: begin
                r_state <= S_DUMP;
                r_count <= '0;
              end
              default: ;
            endcase
          end
        end

        S_STEP: begin
          r_remaining <= r_remaining - 1'b1;
          if (w_stop || (r_remaining == GEN_W'(1))) begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (w_stop) begin
            r_state <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (bus.din_valid) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST_CELL) begin
              r_state <= S_IDLE;
              r_gen   <= '0;
            end
          end
        end

        S_DUMP: begin
          r_count <= r_count + 1'b1;
          if (r_count == LAST_CELL) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // DUMP feeds the chain's tail back into its head so the lattice survives readout.
  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.din_ready  = (r_state == S_LOAD);
  assign bus.cell_en    = w_cell_en;
  assign bus.scan_en    = ((r_state == S_LOAD) && bus.din_valid) || (r_state == S_DUMP);
  assign bus.scan_in    = (r_state == S_LOAD) ? bus.din :
                          (r_state == S_DUMP) ? bus.scan_out : 4'h0;
  assign bus.dout       = (r_state == S_DUMP) ? bus.scan_out : 4'h0;
  assign bus.dout_valid = (r_state == S_DUMP);
  assign bus.rnd        = r_lfsr[NCELLS-1:0];
  assign bus.gen        = r_gen;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
